// File: rtl/rv32_mem_pkg.sv
// Shared RV32I memory-access definitions for the load/store path.
// funct3 size/sign codes, FSM state encoding and a legality helper.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1,
        S_RESP
    } lsu_state_e;

    // Stores only have signed-size codes; unsigned codes are load-only.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-request and data-memory bus bundle for the load/store unit.
// slave = the LSU view, master = the core/memory side.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/shift over an 8-byte window,
// load extraction from two words and sign/zero extension.
module lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  strb,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        two_beat
);

    logic [3:0]  mask;
    logic [2:0]  nbytes;
    logic [31:0] word;

    // Size decode, lane placement and load extension.
    always_comb begin
        mask   = 4'b1111;
        nbytes = 3'd4;
        case (funct3[1:0])
            2'b00: begin
                mask   = 4'b0001;
                nbytes = 3'd1;
            end
            2'b01: begin
                mask   = 4'b0011;
                nbytes = 3'd2;
            end
            default: ;
        endcase
        strb     = {4'b0000, mask} << offset;
        wdata_sh = {32'h0, wdata} << {offset, 3'b000};
        two_beat = ({1'b0, offset} + nbytes) > 3'd4;
        word     = 32'(rdata >> {offset, 3'b000});
        case (funct3)
            F3_B:    rdata_ext = {{24{word[7]}}, word[7:0]};
            F3_H:    rdata_ext = {{16{word[15]}}, word[15:0]};
            F3_BU:   rdata_ext = {24'h0, word[7:0]};
            F3_HU:   rdata_ext = {16'h0, word[15:0]};
            default: rdata_ext = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, split into one or
// two word beats when the access crosses a word boundary.
module load_store_unit
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);

    lsu_state_e        state_q, state_d;
    logic              wr_q;
    logic              err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rd0_q;
    logic [31:0]       rd1_q;

    logic              accept;
    logic              beat_done;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        strb;
    logic [63:0]       wdata_sh;
    logic [31:0]       rdata_ext;
    logic              two_beat;

    assign accept    = bus.req_valid && bus.req_ready;
    assign beat_done = bus.mem_valid && bus.mem_ready;
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     ({rd1_q, rd0_q}),
        .strb      (strb),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .two_beat  (two_beat)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Capture the accepted request and the read words of each beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rd0_q   <= 32'h0;
            rd1_q   <= 32'h0;
        end else begin
            if (accept) begin
                wr_q    <= bus.req_write;
                err_q   <= !f3_legal(bus.req_write, bus.req_funct3);
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rd0_q   <= 32'h0;
                rd1_q   <= 32'h0;
            end
            if (beat_done && !wr_q) begin
                if (state_q == S_BEAT0) rd0_q <= bus.mem_rdata;
                else                    rd1_q <= bus.mem_rdata;
            end
        end
    end

    // Next state and all bus outputs; everything idles at zero.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.mem_valid  = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wstrb  = 4'b0000;
        bus.mem_wdata  = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    state_d = f3_legal(bus.req_write, bus.req_funct3)
                            ? S_BEAT0 : S_RESP;
                end
            end
            S_BEAT0: begin
                bus.mem_valid = 1'b1;
                bus.mem_we    = wr_q;
                bus.mem_addr  = word_addr;
                bus.mem_wstrb = wr_q ? strb[3:0] : 4'b0000;
                bus.mem_wdata = wr_q ? wdata_sh[31:0] : 32'h0;
                if (bus.mem_ready) state_d = two_beat ? S_BEAT1 : S_RESP;
            end
            S_BEAT1: begin
                bus.mem_valid = 1'b1;
                bus.mem_we    = wr_q;
                bus.mem_addr  = word_addr + ADDR_W'(4);
                bus.mem_wstrb = wr_q ? strb[7:4] : 4'b0000;
                bus.mem_wdata = wr_q ? wdata_sh[63:32] : 32'h0;
                if (bus.mem_ready) state_d = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (wr_q || err_q) ? 32'h0 : rdata_ext;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
// Expected values are hand-computed constants.
module tb_load_store_unit;
    import rv32_mem_pkg::*;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;

    load_store_unit_if #(.ADDR_W(AW)) bus ();

    load_store_unit #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int nresp = 0;
    int nbeat = 0;
    int acc_cyc = 0;
    int resp_cyc = 0;
    int unstable = 0;
    int viol = 0;
    logic [31:0] resp_data;
    logic        resp_e;
    logic        pend = 1'b0;
    logic        prev_resp = 1'b0;
    logic [69:0] snap;
    logic [31:0] q_addr [$];
    logic [3:0]  q_strb [$];
    logic [31:0] q_wdata [$];
    logic        q_we [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model, beat log, response log and protocol monitors.
    always @(negedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        if (bus.mem_valid && bus.mem_ready) begin
            q_addr.push_back(bus.mem_addr);
            q_strb.push_back(bus.mem_wstrb);
            q_wdata.push_back(bus.mem_wdata);
            q_we.push_back(bus.mem_we);
            nbeat <= nbeat + 1;
            if (bus.mem_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (bus.mem_wstrb[l])
                        mem[bus.mem_addr[7:2]][8*l +: 8] <= bus.mem_wdata[8*l +: 8];
                end
            end
        end
        if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
        if (bus.resp_valid) begin
            nresp     <= nresp + 1;
            resp_cyc  <= cyc;
            resp_data <= bus.resp_rdata;
            resp_e    <= bus.resp_err;
        end
        if (bus.mem_valid && (bus.req_ready || bus.resp_valid)) viol <= viol + 1;
        if (bus.resp_valid && prev_resp) viol <= viol + 1;
        prev_resp <= bus.resp_valid;
        if (pend && !rst && {bus.mem_valid, bus.mem_we, bus.mem_addr,
                             bus.mem_wstrb, bus.mem_wdata} != snap)
            unstable <= unstable + 1;
        pend <= bus.mem_valid && !bus.mem_ready && !rst;
        snap <= {bus.mem_valid, bus.mem_we, bus.mem_addr,
                 bus.mem_wstrb, bus.mem_wdata};
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] val);
        @(posedge clk); #1;
        poke_en  = 1'b1;
        poke_idx = idx[5:0];
        poke_val = val;
        @(negedge clk); #1;
        poke_en  = 1'b0;
    endtask

    task automatic start_req(input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(posedge clk); #1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("accepted", 64'(n < 20), 64'd1);
    endtask

    task automatic wait_resp(output int lat);
        int n0 = nresp;
        int n = 0;
        while (nresp == n0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        check("resp_seen", 64'(nresp - n0), 64'd1);
        lat = (nresp == n0) ? -1 : resp_cyc - acc_cyc;
    endtask

    int lat;
    int b0;
    int r0;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        poke_en        = 1'b0;
        poke_idx       = 6'd0;
        poke_val       = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.mem_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_wstrb", 64'(bus.mem_wstrb), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rdata", 64'(bus.resp_rdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);

        b0 = nbeat;
        start_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
        wait_resp(lat);
        check("sw_lat", 64'(lat), 64'd2);
        check("sw_beats", 64'(nbeat - b0), 64'd1);
        check("sw_addr", 64'(q_addr[b0]), 64'h10);
        check("sw_we", 64'(q_we[b0]), 64'd1);
        check("sw_strb", 64'(q_strb[b0]), 64'hF);
        check("sw_wdata", 64'(q_wdata[b0]), 64'hDEADBEEF);
        check("sw_err", 64'(resp_e), 64'd0);
        check("sw_rdata", 64'(resp_data), 64'd0);
        check("sw_mem", 64'(mem[4]), 64'hDEADBEEF);

        poke(4, 32'h80FF0000);
        b0 = nbeat;
        start_req(1'b0, F3_B, 32'h13, 32'h0);
        wait_resp(lat);
        check("lb_lat", 64'(lat), 64'd2);
        check("lb_data", 64'(resp_data), 64'hFFFFFF80);
        check("lb_we", 64'(q_we[b0]), 64'd0);
        check("lb_strb", 64'(q_strb[b0]), 64'd0);
        start_req(1'b0, F3_BU, 32'h13, 32'h0);
        wait_resp(lat);
        check("lbu_data", 64'(resp_data), 64'h00000080);

        poke(3, 32'h11223344);
        poke(4, 32'h55667788);
        b0 = nbeat;
        start_req(1'b0, F3_W, 32'h0E, 32'h0);
        wait_resp(lat);
        check("lw_mis_beats", 64'(nbeat - b0), 64'd2);
        check("lw_mis_a0", 64'(q_addr[b0]), 64'h0C);
        check("lw_mis_a1", 64'(q_addr[b0+1]), 64'h10);
        check("lw_mis_data", 64'(resp_data), 64'h77881122);
        check("lw_mis_lat", 64'(lat), 64'd3);

        poke(1, 32'h0);
        poke(2, 32'h0);
        b0 = nbeat;
        start_req(1'b1, F3_H, 32'h07, 32'h0000ABCD);
        wait_resp(lat);
        check("sh_beats", 64'(nbeat - b0), 64'd2);
        check("sh_a0", 64'(q_addr[b0]), 64'h04);
        check("sh_s0", 64'(q_strb[b0]), 64'b1000);
        check("sh_d0", 64'(q_wdata[b0]), 64'hCD000000);
        check("sh_a1", 64'(q_addr[b0+1]), 64'h08);
        check("sh_s1", 64'(q_strb[b0+1]), 64'b0001);
        check("sh_d1", 64'(q_wdata[b0+1]), 64'h000000AB);
        check("sh_mem1", 64'(mem[1]), 64'hCD000000);
        check("sh_mem2", 64'(mem[2]), 64'h000000AB);

        poke(1, 32'h9ABC0000);
        start_req(1'b0, F3_H, 32'h06, 32'h0);
        wait_resp(lat);
        check("lh_data", 64'(resp_data), 64'hFFFF9ABC);
        start_req(1'b0, F3_HU, 32'h06, 32'h0);
        wait_resp(lat);
        check("lhu_data", 64'(resp_data), 64'h00009ABC);

        b0 = nbeat;
        start_req(1'b0, 3'b011, 32'h10, 32'h0);
        wait_resp(lat);
        check("ill_ld_beats", 64'(nbeat - b0), 64'd0);
        check("ill_ld_err", 64'(resp_e), 64'd1);
        check("ill_ld_data", 64'(resp_data), 64'd0);
        check("ill_ld_lat", 64'(lat), 64'd1);
        b0 = nbeat;
        start_req(1'b1, F3_BU, 32'h10, 32'hFFFFFFFF);
        wait_resp(lat);
        check("ill_st_beats", 64'(nbeat - b0), 64'd0);
        check("ill_st_err", 64'(resp_e), 64'd1);
        check("ill_st_mem", 64'(mem[4]), 64'h55667788);

        poke(8, 32'hCAFEF00D);
        bus.mem_ready = 1'b0;
        b0 = nbeat;
        start_req(1'b0, F3_W, 32'h20, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        wait_resp(lat);
        check("stall_lat", 64'(lat), 64'd5);
        check("stall_beats", 64'(nbeat - b0), 64'd1);
        check("stall_data", 64'(resp_data), 64'hCAFEF00D);
        check("stall_stable", 64'(unstable), 64'd0);

        poke(63, 32'h34000000);
        poke(0, 32'h00000012);
        b0 = nbeat;
        start_req(1'b0, F3_H, 32'hFFFFFFFF, 32'h0);
        wait_resp(lat);
        check("wrap_a0", 64'(q_addr[b0]), 64'hFFFFFFFC);
        check("wrap_a1", 64'(q_addr[b0+1]), 64'h0);
        check("wrap_data", 64'(resp_data), 64'h00001234);

        poke(11, 32'h0);
        start_req(1'b1, F3_W, 32'h2E, 32'h11223344);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("b1_valid", 64'(bus.mem_valid), 64'd1);
        check("b1_addr", 64'(bus.mem_addr), 64'h30);
        r0 = nresp;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_b1_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_b1_ready", 64'(bus.req_ready), 64'd0);
        check("rst_b1_addr", 64'(bus.mem_addr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("rst_b1_ready_rel", 64'(bus.req_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("rst_b1_no_resp", 64'(nresp - r0), 64'd0);
        check("rst_b1_partial", 64'(mem[11][31:16]), 64'h3344);

        start_req(1'b0, F3_W, 32'h10, 32'h0);
        wait_resp(lat);
        check("post_rst_lw", 64'(resp_data), 64'h55667788);

        repeat (2) @(negedge clk);
        check("protocol_viol", 64'(viol), 64'd0);
        check("beat_stable", 64'(unstable), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
